tag_array_ctrl: RTL and testbench
=================================

# tag_array_ctrl

Front-end controller for the cache tag SRAM (128 sets × 4 ways × 20-bit entries, single-port, one write-masked port). It performs the post-reset invalidation sweep and arbitrates lookup reads against tag-update writes, with writes taking priority. It presents the lookup response with a fixed one-cycle latency. It sits between the cache pipeline's tag-lookup/refill logic and the tag SRAM template instance.

## Interface
- SETS, 128, number of sets (address width = log2(SETS) = 7)
- WAYS, 4, ways per set (= write-mask width)
- ENTRY_W, 20, bits per way entry; row width = WAYS*ENTRY_W = 80
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  lookup request
- req_ready  out  1  lookup accepted when valid&ready
- req_set  in  7  lookup set index
- resp_valid  out  1  lookup response valid (no backpressure)
- resp_data  out  80  way entries, way w at bits [w*20 +: 20]
- wr_valid  in  1  tag update request
- wr_ready  out  1  update accepted when valid&ready
- wr_set  in  7  update set index
- wr_data  in  80  update row
- wr_mask  in  4  per-way write enable
- init_done  out  1  sweep complete
- sram_r_addr  out  7  to SRAM read address
- sram_r_data  in  80  from SRAM, valid the cycle after the read address
- sram_w_en / sram_w_addr / sram_w_data / sram_w_mask  out  1/7/80/4  to SRAM write port

## Operation
- States: INIT, RUN. Reset → INIT, sweep counter = 0.
- INIT: each cycle sram_w_en=1, sram_w_addr=counter, sram_w_data=0, sram_w_mask=4'hF; counter increments. After the write of set 127 → RUN. req_ready=wr_ready=0 throughout.
- RUN: wr_ready=1; req_ready = !wr_valid (write priority, single port).
- Accepted write: sram_w_en=1, addr/data/mask pass straight through the same cycle.
- Accepted read: sram_r_addr=req_set, sram_w_en=0. resp_valid=1 next cycle, resp_data=sram_r_data.
- With no accepted read, sram_r_addr still follows req_set. sram_w_* data lines are don't-care when sram_w_en=0.
- Reset mid-sweep or mid-lookup: counter restarts at 0, pending resp_valid is dropped, init_done clears.

## Timing
- Reset values: req_ready=0, wr_ready=0, resp_valid=0, init_done=0, sram_w_en=0 during the reset cycle.
- Sweep: first post-reset cycle writes set 0; set 127 is written in cycle 128. init_done=1 and RUN begin in cycle 129.
- Lookup latency: exactly 1 cycle, back-to-back lookups at full rate.
- A read and a write presented in the same cycle: the write goes and the read stalls; a continuous write stream starves reads by design.
- resp_valid is a single-cycle pulse per accepted read. The consumer must capture it.

## Configuration
- TAG_WR_FORWARD_EN defined: if a write is accepted in the same cycle a response is presented, and wr_set equals the set of that response, the ways selected by wr_mask in resp_data are replaced by the matching slices of wr_data. This gives a combinational merge.
- Not defined: resp_data = sram_r_data unconditionally; the consumer resolves the hazard itself.

## Structure
- Package tag_array_pkg holds:
  - SETS, WAYS, ENTRY_W, SET_W
  - typedef tag_row_t (WAYS × ENTRY_W packed array)
  - enum ctrl_state_e {INIT, RUN}
- Single module. The registered response set index and the forward-merge function stay local, and no sub-module is warranted.

## Test plan
- Reset for 3 cycles, then release → sram_w_en high for exactly 128 cycles with addr 0..127, mask F, data 0; init_done rises in cycle 129; req_ready/wr_ready stay 0 until then.
- Write set 5 with data 80'h1 and mask 4'h1, then read set 5 → resp_valid one cycle after acceptance, resp_data=80'h1.
- wr_valid and req_valid asserted together for 3 cycles (sets 9/10) → 3 writes issued; req_ready=0 for all 3; read accepted on the 4th cycle.
- Read set 7 (holding 80'hAAAA); in the response cycle write set 7, mask 4'h2, data with way 1=20'h12345 → forward on: resp way1=20'h12345, others unchanged; forward off: 80'hAAAA.
- Assert reset at sweep counter 60 → sweep restarts at set 0, init_done arrives 128 cycles after the new release.
- Back-to-back reads of sets 0..3 → 4 consecutive resp_valid pulses with the matching rows in order.

Source files
------------

// File: rtl/tag_array_pkg.sv
// Shared parameters and types for the cache tag-array front-end controller.
package tag_array_pkg;

  localparam int SETS    = 128;
  localparam int WAYS    = 4;
  localparam int ENTRY_W = 20;
  localparam int SET_W   = $clog2(SETS);
  localparam int ROW_W   = WAYS * ENTRY_W;

  // Index of the final set written by the post-reset invalidation sweep.
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

  typedef logic [WAYS-1:0][ENTRY_W-1:0] tag_row_t;

  typedef enum logic {
    INIT,
    RUN
  } ctrl_state_e;

endpackage

// File: rtl/tag_array_ctrl.sv
// Tag SRAM front-end: post-reset invalidation sweep, write-priority
// arbitration of lookups against tag updates, one-cycle lookup response.
// Optional macro TAG_WR_FORWARD_EN merges a same-cycle update to the
// responding set into resp_data; without it resp_data is the raw SRAM row.
module tag_array_ctrl
  import tag_array_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SET_W-1:0]   req_set,
  output logic               resp_valid,
  output logic [ROW_W-1:0]   resp_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [SET_W-1:0]   wr_set,
  input  logic [ROW_W-1:0]   wr_data,
  input  logic [WAYS-1:0]    wr_mask,
  output logic               init_done,
  output logic [SET_W-1:0]   sram_r_addr,
  input  logic [ROW_W-1:0]   sram_r_data,
  output logic               sram_w_en,
  output logic [SET_W-1:0]   sram_w_addr,
  output logic [ROW_W-1:0]   sram_w_data,
  output logic [WAYS-1:0]    sram_w_mask
);

  ctrl_state_e      state_q, state_d;
  logic [SET_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic             resp_valid_q;
  logic             rd_fire;
  logic             wr_fire;

  // State and sweep counter; reset always restarts the sweep from set 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INIT;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  // Next state, handshakes and SRAM write port; everything is quiet while reset is high.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    req_ready   = 1'b0;
    wr_ready    = 1'b0;
    sram_w_en   = 1'b0;
    sram_w_addr = wr_set;
    sram_w_data = wr_data;
    sram_w_mask = wr_mask;
    case (state_q)
      INIT: begin
        if (!reset) begin
          sram_w_en   = 1'b1;
          sram_w_addr = sweep_cnt_q;
          sram_w_data = '0;
          sram_w_mask = '1;
          sweep_cnt_d = sweep_cnt_q + SET_W'(1);
          if (sweep_cnt_q == LAST_SET) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!reset) begin
          wr_ready  = 1'b1;
          req_ready = !wr_valid;
          sram_w_en = wr_valid;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  assign rd_fire     = req_valid && req_ready;
  assign wr_fire     = wr_valid && wr_ready;
  assign sram_r_addr = req_set;
  assign init_done   = (state_q == RUN) && !reset;
  assign resp_valid  = resp_valid_q && !reset;

  // One-cycle response pulse for every accepted lookup.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
    end else begin
      resp_valid_q <= rd_fire;
    end
  end

`ifdef TAG_WR_FORWARD_EN
  logic [SET_W-1:0] resp_set_q;

  // Replace the masked ways of the SRAM row with the in-flight update.
  function automatic tag_row_t merge_row(input tag_row_t base, input tag_row_t upd,
                                         input logic [WAYS-1:0] mask);
    tag_row_t res;
    res = base;
    for (int w = 0; w < WAYS; w++) begin
      if (mask[w]) begin
        res[w] = upd[w];
      end
    end
    return res;
  endfunction

  // Remember which set the pending response belongs to for hazard detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_set_q <= '0;
    end else if (rd_fire) begin
      resp_set_q <= req_set;
    end
  end

  // Forward a same-cycle update into the response so the consumer sees fresh tags.
  always_comb begin
    resp_data = sram_r_data;
    if (resp_valid_q && wr_fire && (wr_set == resp_set_q)) begin
      resp_data = merge_row(tag_row_t'(sram_r_data), tag_row_t'(wr_data), wr_mask);
    end
  end
`else
  logic unused_wr_fire;

  // The consumer resolves update/response hazards itself.
  assign resp_data      = sram_r_data;
  assign unused_wr_fire = wr_fire;
`endif

endmodule

// File: tb/tb_tag_array_ctrl.sv
// Self-checking bench for tag_array_ctrl: SRAM model, behavioural reference
// model with a per-cycle compare process, directed scenarios and random traffic.
module tb_tag_array_ctrl;
  import tag_array_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               req_valid;
  logic               req_ready;
  logic [SET_W-1:0]   req_set;
  logic               resp_valid;
  logic [ROW_W-1:0]   resp_data;
  logic               wr_valid;
  logic               wr_ready;
  logic [SET_W-1:0]   wr_set;
  logic [ROW_W-1:0]   wr_data;
  logic [WAYS-1:0]    wr_mask;
  logic               init_done;
  logic [SET_W-1:0]   sram_r_addr;
  logic [ROW_W-1:0]   sram_r_data;
  logic               sram_w_en;
  logic [SET_W-1:0]   sram_w_addr;
  logic [ROW_W-1:0]   sram_w_data;
  logic [WAYS-1:0]    sram_w_mask;

  int n_compared = 0;
  int n_mismatch = 0;

  bit             started = 1'b0;
  bit             pin_armed = 1'b0;
  logic [ROW_W-1:0] pin_row = '0;
  string          pin_name = "";

  always #5 clock = ~clock;

  tag_array_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_set     (req_set),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_set      (wr_set),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .init_done   (init_done),
    .sram_r_addr (sram_r_addr),
    .sram_r_data (sram_r_data),
    .sram_w_en   (sram_w_en),
    .sram_w_addr (sram_w_addr),
    .sram_w_data (sram_w_data),
    .sram_w_mask (sram_w_mask)
  );

  // Tag SRAM: masked write, registered read one cycle after the address.
  logic [ROW_W-1:0] sram_mem [SETS];
  always @(posedge clock) begin
    for (int w = 0; w < WAYS; w++) begin
      if (sram_w_en && sram_w_mask[w]) begin
        sram_mem[sram_w_addr][w*ENTRY_W +: ENTRY_W] <= sram_w_data[w*ENTRY_W +: ENTRY_W];
      end
    end
    sram_r_data <= sram_mem[sram_r_addr];
  end

  // Reference model state: cycles since release, table contents, pending response.
  int               post_cycles = 0;
  logic [ROW_W-1:0] shadow [SETS];
  bit               pend_v = 1'b0;
  logic [ROW_W-1:0] pend_row = '0;
  int               pend_set = 0;

  task automatic check_output(input string name, input logic [ROW_W-1:0] act,
                              input logic [ROW_W-1:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compare every DUT output with the model mid-cycle, then advance the model.
  always @(negedge clock) begin
    logic [ROW_W-1:0] exp_resp;
    bit wr_acc;
    bit rd_acc;
    if (started) begin
      if (reset) begin
        check_output("rst_req_ready", ROW_W'(req_ready), '0);
        check_output("rst_wr_ready", ROW_W'(wr_ready), '0);
        check_output("rst_resp_valid", ROW_W'(resp_valid), '0);
        check_output("rst_init_done", ROW_W'(init_done), '0);
        check_output("rst_sram_w_en", ROW_W'(sram_w_en), '0);
        post_cycles = 0;
        pend_v = 1'b0;
      end else if (post_cycles < SETS) begin
        check_output("sweep_init_done", ROW_W'(init_done), '0);
        check_output("sweep_req_ready", ROW_W'(req_ready), '0);
        check_output("sweep_wr_ready", ROW_W'(wr_ready), '0);
        check_output("sweep_resp_valid", ROW_W'(resp_valid), '0);
        check_output("sweep_w_en", ROW_W'(sram_w_en), ROW_W'(1));
        check_output("sweep_w_addr", ROW_W'(sram_w_addr), ROW_W'(post_cycles));
        check_output("sweep_w_data", sram_w_data, '0);
        check_output("sweep_w_mask", ROW_W'(sram_w_mask), ROW_W'(4'hF));
        check_output("sweep_r_addr", ROW_W'(sram_r_addr), ROW_W'(req_set));
        shadow[post_cycles] = '0;
        pend_v = 1'b0;
        post_cycles++;
      end else begin
        wr_acc = (wr_valid === 1'b1);
        rd_acc = (req_valid === 1'b1) && !wr_acc;
        check_output("run_init_done", ROW_W'(init_done), ROW_W'(1));
        check_output("run_wr_ready", ROW_W'(wr_ready), ROW_W'(1));
        check_output("run_req_ready", ROW_W'(req_ready), ROW_W'(!wr_acc));
        check_output("run_w_en", ROW_W'(sram_w_en), ROW_W'(wr_acc));
        check_output("run_r_addr", ROW_W'(sram_r_addr), ROW_W'(req_set));
        if (wr_acc) begin
          check_output("run_w_addr", ROW_W'(sram_w_addr), ROW_W'(wr_set));
          check_output("run_w_data", sram_w_data, wr_data);
          check_output("run_w_mask", ROW_W'(sram_w_mask), ROW_W'(wr_mask));
        end
        check_output("run_resp_valid", ROW_W'(resp_valid), ROW_W'(pend_v));
        if (pend_v) begin
          exp_resp = pend_row;
`ifdef TAG_WR_FORWARD_EN
          if (wr_acc && (int'(wr_set) == pend_set)) begin
            for (int w = 0; w < WAYS; w++) begin
              if (wr_mask[w]) begin
                exp_resp[w*ENTRY_W +: ENTRY_W] = wr_data[w*ENTRY_W +: ENTRY_W];
              end
            end
          end
`endif
          check_output("run_resp_data", resp_data, exp_resp);
        end
        if (pin_armed) begin
          check_output({pin_name, "_valid"}, ROW_W'(resp_valid), ROW_W'(1));
          check_output({pin_name, "_data"}, resp_data, pin_row);
        end
        if (wr_acc) begin
          for (int w = 0; w < WAYS; w++) begin
            if (wr_mask[w]) begin
              shadow[wr_set][w*ENTRY_W +: ENTRY_W] = wr_data[w*ENTRY_W +: ENTRY_W];
            end
          end
        end
        pend_v = rd_acc;
        if (rd_acc) begin
          pend_row = shadow[req_set];
          pend_set = int'(req_set);
        end
        post_cycles++;
      end
    end
  end

  // Drive one cycle of inputs, then advance past the next rising edge.
  task automatic apply_stimulus(input bit rst, input bit wv, input int ws,
                                input logic [ROW_W-1:0] wd, input logic [WAYS-1:0] wm,
                                input bit rv, input int rs);
    reset     = rst;
    wr_valid  = wv;
    wr_set    = SET_W'(ws);
    wr_data   = wd;
    wr_mask   = wm;
    req_valid = rv;
    req_set   = SET_W'(rs);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b0, 1'b0, 0, '0, '0, 1'b0, 0);
    end
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [ROW_W-1:0] fwd_exp;
    reset = 1'b1; wr_valid = 1'b0; req_valid = 1'b0;
    wr_set = '0; req_set = '0; wr_data = '0; wr_mask = '0;
    @(posedge clock);
    #1;
    started = 1'b1;
    apply_stimulus(1'b1, 1'b0, 0, '0, '0, 1'b0, 0);
    apply_stimulus(1'b1, 1'b0, 0, '0, '0, 1'b0, 0);
    idle(SETS + 1);

    // Masked write of set 5 followed by a lookup of set 5.
    apply_stimulus(1'b0, 1'b1, 5, 80'h1, 4'h1, 1'b0, 0);
    apply_stimulus(1'b0, 1'b0, 0, '0, '0, 1'b1, 5);
    pin_armed = 1'b1; pin_name = "pin_set5"; pin_row = 80'h1;
    idle(1);
    pin_armed = 1'b0;

    // Write and read collide for three cycles; the read goes on the fourth.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 9, rand_row(), 4'hF, 1'b1, 10);
    end
    apply_stimulus(1'b0, 1'b0, 0, '0, '0, 1'b1, 10);
    idle(2);

    // Update to set 7 in the same cycle as its lookup response.
    apply_stimulus(1'b0, 1'b1, 7, 80'hAAAA, 4'hF, 1'b0, 0);
    apply_stimulus(1'b0, 1'b0, 0, '0, '0, 1'b1, 7);
`ifdef TAG_WR_FORWARD_EN
    fwd_exp = 80'h0000000000123450AAAA;
`else
    fwd_exp = 80'hAAAA;
`endif
    pin_armed = 1'b1; pin_name = "pin_fwd_set7"; pin_row = fwd_exp;
    apply_stimulus(1'b0, 1'b1, 7, 80'h0000000000123450_0000, 4'h2, 1'b0, 0);
    pin_armed = 1'b0;
    idle(2);

    // Distinct rows in sets 0..3, then back-to-back lookups.
    for (int s = 0; s < 4; s++) begin
      apply_stimulus(1'b0, 1'b1, s, rand_row(), 4'hF, 1'b0, 0);
    end
    for (int s = 0; s < 4; s++) begin
      apply_stimulus(1'b0, 1'b0, 0, '0, '0, 1'b1, s);
    end
    idle(2);

    // Reset in the middle of a sweep restarts it from set 0.
    apply_stimulus(1'b1, 1'b0, 0, '0, '0, 1'b0, 0);
    idle(60);
    apply_stimulus(1'b1, 1'b0, 0, '0, '0, 1'b0, 0);
    idle(SETS + 2);

    // Random traffic over a small set range to provoke hazards and collisions.
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus($urandom_range(0, 799) == 0,
                     $urandom_range(0, 9) < 3, int'($urandom_range(0, 15)), rand_row(),
                     WAYS'($urandom), $urandom_range(0, 9) < 6, int'($urandom_range(0, 15)));
    end
    idle(SETS + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
